// File: rtl/memory_in_arbiter.sv
// Request-side memory arbiter: grants cache or instruction fetch, then runs a 4-phase req/ack to memory.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates tie winners; without it instruction fetch always wins ties.
module memory_in_arbiter #(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_req,
    input  logic [DATA_W-1:0] instr_in,
    output logic              instr_ack,
    input  logic              cache_req,
    input  logic [DATA_W-1:0] cache_in,
    output logic              cache_ack,
    output logic [DATA_W-1:0] mem_out,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [1:0]        PH0,
    output logic [1:0]        PH1,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0] PH_ACTIVE = 2'b10;
    localparam logic [1:0] PH_IDLE   = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_REQ   = 3'd2,
        S_REL   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_CACHE = 1'b1
    } gnt_t;

    state_t            state_q, state_d;
    gnt_t              grant_q, grant_d;
    logic [DATA_W-1:0] mem_out_q, mem_out_d;
    logic              mem_req_q, mem_req_d;
    logic              instr_ack_q, instr_ack_d;
    logic              cache_ack_q, cache_ack_d;
    logic              timeout_err_q, timeout_err_d;
    logic              rel_hold_q, rel_hold_d;
    logic [1:0]        ph0_q, ph0_d;
    logic [1:0]        ph1_q, ph1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              timeout_hit_s;
    logic              pick_cache_s;
    logic              owner_released_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    gnt_t              last_grant_q, last_grant_d;
`endif

    // Winner selection for the IDLE grant
    always_comb begin
        pick_cache_s = 1'b0;
        if (instr_req && cache_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_cache_s = (last_grant_q == GNT_INSTR);
`else
            pick_cache_s = 1'b0;
`endif
        end else if (cache_req) begin
            pick_cache_s = 1'b1;
        end else begin
            pick_cache_s = 1'b0;
        end
    end

    // Saturating timeout counter increment and abort detection
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_W'(1);
        end
        timeout_hit_s    = (TIMEOUT_CYCLES != 0) && (cnt_inc_s == CNT_LIMIT);
        owner_released_s = (grant_q == GNT_CACHE) ? !cache_req : !instr_req;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mem_out_d     = mem_out_q;
        mem_req_d     = mem_req_q;
        instr_ack_d   = instr_ack_q;
        cache_ack_d   = cache_ack_q;
        timeout_err_d = 1'b0;
        rel_hold_d    = rel_hold_q;
        ph0_d         = ph0_q;
        ph1_d         = ph1_q;
        cnt_d         = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((instr_req || cache_req) && !mem_ack) begin
                    state_d = S_SETUP;
                    if (pick_cache_s) begin
                        grant_d   = GNT_CACHE;
                        mem_out_d = cache_in;
                        ph0_d     = PH_IDLE;
                        ph1_d     = PH_ACTIVE;
                    end else begin
                        grant_d   = GNT_INSTR;
                        mem_out_d = instr_in;
                        ph0_d     = PH_ACTIVE;
                        ph1_d     = PH_IDLE;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = pick_cache_s ? GNT_CACHE : GNT_INSTR;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                mem_req_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_REQ;
            end
            S_REQ: begin
                cnt_d = cnt_inc_s;
                if (timeout_hit_s) begin
                    timeout_err_d = 1'b1;
                    mem_req_d     = 1'b0;
                    mem_out_d     = '0;
                    ph0_d         = PH_IDLE;
                    ph1_d         = PH_IDLE;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    rel_hold_d = 1'b1;
                    state_d    = S_REL;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REL: begin
                // rel_hold_q spaces the requester ack two cycles past the mem_req fall
                cnt_d      = cnt_inc_s;
                rel_hold_d = 1'b0;
                if (timeout_hit_s) begin
                    timeout_err_d = 1'b1;
                    mem_req_d     = 1'b0;
                    mem_out_d     = '0;
                    ph0_d         = PH_IDLE;
                    ph1_d         = PH_IDLE;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else if (!mem_ack && !rel_hold_q) begin
                    mem_out_d = '0;
                    ph0_d     = PH_IDLE;
                    ph1_d     = PH_IDLE;
                    if (grant_q == GNT_CACHE) begin
                        cache_ack_d = 1'b1;
                    end else begin
                        instr_ack_d = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    state_d = S_REL;
                end
            end
            S_DONE: begin
                if (owner_released_s) begin
                    instr_ack_d = 1'b0;
                    cache_ack_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                mem_req_d   = 1'b0;
                mem_out_d   = '0;
                instr_ack_d = 1'b0;
                cache_ack_d = 1'b0;
                ph0_d       = PH_IDLE;
                ph1_d       = PH_IDLE;
                cnt_d       = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= GNT_INSTR;
            mem_out_q     <= '0;
            mem_req_q     <= 1'b0;
            instr_ack_q   <= 1'b0;
            cache_ack_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            rel_hold_q    <= 1'b0;
            ph0_q         <= PH_IDLE;
            ph1_q         <= PH_IDLE;
            cnt_q         <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q  <= GNT_CACHE;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mem_out_q     <= mem_out_d;
            mem_req_q     <= mem_req_d;
            instr_ack_q   <= instr_ack_d;
            cache_ack_q   <= cache_ack_d;
            timeout_err_q <= timeout_err_d;
            rel_hold_q    <= rel_hold_d;
            ph0_q         <= ph0_d;
            ph1_q         <= ph1_d;
            cnt_q         <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign mem_out     = mem_out_q;
    assign mem_req     = mem_req_q;
    assign instr_ack   = instr_ack_q;
    assign cache_ack   = cache_ack_q;
    assign PH0         = ph0_q;
    assign PH1         = ph1_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_memory_in_arbiter.sv
// Scoreboard bench for memory_in_arbiter: directed transactions push expected events, a monitor checks them.
`timescale 1ns/1ps
module tb_memory_in_arbiter;

    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_req, cache_req, mem_ack;
    logic [DW-1:0] instr_in, cache_in;
    logic          instr_ack, cache_ack, mem_req, timeout_err;
    logic [DW-1:0] mem_out;
    logic [1:0]    PH0, PH1;

    memory_in_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_in(instr_in), .instr_ack(instr_ack),
        .cache_req(cache_req), .cache_in(cache_in), .cache_ack(cache_ack),
        .mem_out(mem_out), .mem_req(mem_req), .mem_ack(mem_ack),
        .PH0(PH0), .PH1(PH1), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // kind: 0 = memory launch, 1 = instr ack, 2 = cache ack, 3 = timeout abort
    typedef struct {
        int          kind;
        logic [15:0] data;
        logic [1:0]  ph0;
        logic [1:0]  ph1;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    bit  mem_mute  = 1'b0;
    bit  mem_stuck = 1'b0;
    int  wait_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] data, input logic [1:0] p0, input logic [1:0] p1);
        ev_t e;
        e.kind = kind; e.data = data; e.ph0 = p0; e.ph1 = p1;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input int kind, output bit ok);
        n_vec++;
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: actual kind=%0d required no event (t=%0t)", kind, $time);
        end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.kind != kind) begin
                n_err++;
                $display("FAIL event_order: actual kind=%0d required kind=%0d (t=%0t)", kind, mon_e.kind, $time);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks after a short delay, drops ack once mem_req falls
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_stuck) begin
                mem_ack = 1'b1;
            end else if (mem_ack) begin
                if (!mem_req) mem_ack = 1'b0;
            end else if (mem_req && !mem_mute) begin
                if (wait_cnt == 2) begin mem_ack = 1'b1; wait_cnt = 0; end
                else wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every launch, ack and abort edge
    logic       p_req = 1'b0, p_iack = 1'b0, p_cack = 1'b0, p_to = 1'b0;
    logic [1:0] p_ph0 = 2'b01, p_ph1 = 2'b01;
    logic [15:0] p_out = 16'h0000;
    int rise_cyc = 0, fall_cyc = 0;
    bit mon_ok;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("ph_legal", {31'd0, ((PH0 == 2'b01 || PH0 == 2'b10) && (PH1 == 2'b01 || PH1 == 2'b10)
                                     && !(PH0 == 2'b10 && PH1 == 2'b10))}, 32'd1);
            if (mem_out !== 16'h0000)
                chk("mem_out_only_active", {31'd0, (PH0 == 2'b10 || PH1 == 2'b10)}, 32'd1);
            if (timeout_err) chk("to_single_cycle", {31'd0, p_to}, 32'd0);
            if (mem_req && !p_req) begin
                pop_ev(0, mon_ok);
                if (mon_ok) begin
                    chk("launch_data", {16'd0, mem_out}, {16'd0, mon_e.data});
                    chk("launch_ph0", {30'd0, PH0}, {30'd0, mon_e.ph0});
                    chk("launch_ph1", {30'd0, PH1}, {30'd0, mon_e.ph1});
                    chk("setup_data", {16'd0, p_out}, {16'd0, mon_e.data});
                    chk("setup_ph0", {30'd0, p_ph0}, {30'd0, mon_e.ph0});
                    chk("setup_ph1", {30'd0, p_ph1}, {30'd0, mon_e.ph1});
                end
                rise_cyc = cyc;
            end
            if (!mem_req && p_req) fall_cyc = cyc;
            if ((instr_ack && !p_iack) || (cache_ack && !p_cack)) begin
                pop_ev(instr_ack ? 1 : 2, mon_ok);
                if (mon_ok) begin
                    chk("ack_exclusive", {31'd0, instr_ack & cache_ack}, 32'd0);
                    chk("ack_mem_out", {16'd0, mem_out}, 32'd0);
                    chk("ack_ph0", {30'd0, PH0}, 32'd1);
                    chk("ack_ph1", {30'd0, PH1}, 32'd1);
                    chk("ack_mem_ack_low", {31'd0, mem_ack}, 32'd0);
                    chk("ack_gap_ge2", {31'd0, ((cyc - fall_cyc) >= 2)}, 32'd1);
                end
            end
            if (timeout_err && !p_to) begin
                pop_ev(3, mon_ok);
                if (mon_ok) begin
                    chk("to_mem_req", {31'd0, mem_req}, 32'd0);
                    chk("to_mem_out", {16'd0, mem_out}, 32'd0);
                    chk("to_ph0", {30'd0, PH0}, 32'd1);
                    chk("to_ph1", {30'd0, PH1}, 32'd1);
                    chk("to_latency", cyc - rise_cyc, TMO);
                    chk("to_no_ack", {30'd0, instr_ack, cache_ack}, 32'd0);
                end
            end
        end
        p_req = mem_req; p_iack = instr_ack; p_cack = cache_ack; p_to = timeout_err;
        p_ph0 = PH0; p_ph1 = PH1; p_out = mem_out;
    end

    task automatic instr_txn(input logic [15:0] w, input bit scramble);
        int t;
        instr_in = w; instr_req = 1'b1;
        t = 0;
        while (instr_ack !== 1'b1 && t < 200) begin
            @(negedge clk); t++;
            if (scramble && PH0 == 2'b10) instr_in = 16'hFFFF;
        end
        chk("instr_ack_seen", {31'd0, (t < 200)}, 32'd1);
        instr_req = 1'b0;
        t = 0;
        while (instr_ack !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        chk("instr_ack_drop", {31'd0, (t < 20)}, 32'd1);
        instr_in = 16'h0000;
    endtask

    task automatic cache_txn(input logic [15:0] w, input bit scramble);
        int t;
        cache_in = w; cache_req = 1'b1;
        t = 0;
        while (cache_ack !== 1'b1 && t < 200) begin
            @(negedge clk); t++;
            if (scramble && PH1 == 2'b10) cache_in = 16'hFFFF;
        end
        chk("cache_ack_seen", {31'd0, (t < 200)}, 32'd1);
        cache_req = 1'b0;
        t = 0;
        while (cache_ack !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        chk("cache_ack_drop", {31'd0, (t < 20)}, 32'd1);
        cache_in = 16'h0000;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_out"}, {16'd0, mem_out}, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_instr_ack"}, {31'd0, instr_ack}, 32'd0);
        chk({tag, "_cache_ack"}, {31'd0, cache_ack}, 32'd0);
        chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
        chk({tag, "_ph0"}, {30'd0, PH0}, 32'd1);
        chk({tag, "_ph1"}, {30'd0, PH1}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst_n = 1'b0; instr_req = 1'b0; cache_req = 1'b0;
        instr_in = 16'h0000; cache_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Instruction fetch alone
        push(0, 16'h8123, 2'b10, 2'b01); push(1, 16'h0000, 2'b01, 2'b01);
        instr_txn(16'h8123, 1'b1);
        repeat (3) @(negedge clk);

        // Cache alone
        push(0, 16'h4ABC, 2'b01, 2'b10); push(2, 16'h0000, 2'b01, 2'b01);
        cache_txn(16'h4ABC, 1'b1);
        repeat (3) @(negedge clk);

        // Tie after a cache grant: instr wins in both modes
        push(0, 16'hC001, 2'b10, 2'b01); push(1, 16'h0000, 2'b01, 2'b01);
        push(0, 16'h4002, 2'b01, 2'b10); push(2, 16'h0000, 2'b01, 2'b01);
        fork
            instr_txn(16'hC001, 1'b1);
            cache_txn(16'h4002, 1'b1);
        join
        repeat (3) @(negedge clk);

        // Tie after an instr grant: round-robin hands it to the cache
        push(0, 16'h8111, 2'b10, 2'b01); push(1, 16'h0000, 2'b01, 2'b01);
        instr_txn(16'h8111, 1'b1);
        repeat (2) @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(0, 16'h4006, 2'b01, 2'b10); push(2, 16'h0000, 2'b01, 2'b01);
        push(0, 16'hC005, 2'b10, 2'b01); push(1, 16'h0000, 2'b01, 2'b01);
`else
        push(0, 16'hC005, 2'b10, 2'b01); push(1, 16'h0000, 2'b01, 2'b01);
        push(0, 16'h4006, 2'b01, 2'b10); push(2, 16'h0000, 2'b01, 2'b01);
`endif
        fork
            instr_txn(16'hC005, 1'b1);
            cache_txn(16'h4006, 1'b1);
        join
        repeat (3) @(negedge clk);

        // Memory never acks: abort, then the held request retries
        mem_mute = 1'b1;
        push(0, 16'h8555, 2'b10, 2'b01); push(3, 16'h0000, 2'b01, 2'b01);
        push(0, 16'h8555, 2'b10, 2'b01); push(1, 16'h0000, 2'b01, 2'b01);
        fork
            instr_txn(16'h8555, 1'b0);
            begin
                t = 0;
                while (timeout_err !== 1'b1 && t < 60) begin @(negedge clk); t++; end
                chk("timeout_seen", {31'd0, (t < 60)}, 32'd1);
                mem_mute = 1'b0;
            end
        join
        repeat (3) @(negedge clk);

        // mem_ack stuck high blocks the grant
        mem_stuck = 1'b1;
        repeat (2) @(negedge clk);
        push(0, 16'h8999, 2'b10, 2'b01); push(1, 16'h0000, 2'b01, 2'b01);
        fork
            instr_txn(16'h8999, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stuck_ph0", {30'd0, PH0}, 32'd1);
                    chk("stuck_ph1", {30'd0, PH1}, 32'd1);
                    chk("stuck_mem_req", {31'd0, mem_req}, 32'd0);
                end
                mem_stuck = 1'b0;
            end
        join
        repeat (3) @(negedge clk);

        // Reset during REQ: no ack for the aborted transfer
        mem_mute = 1'b1;
        push(0, 16'h8777, 2'b10, 2'b01);
        instr_in = 16'h8777; instr_req = 1'b1;
        t = 0;
        while (mem_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        chk("rst_test_req_seen", {31'd0, (t < 20)}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; instr_req = 1'b0; instr_in = 16'h0000;
        @(posedge clk);
        #1 chk_reset_outputs("midreset");
        @(negedge clk) rst_n = 1'b1;
        mem_mute = 1'b0;
        repeat (12) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
